uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
UART receiver, 8N1, LSB first, for the FPGA UART IP. It is the receive-side counterpart of uart_tx_core and uses the same parameter set, so the two pair at a common baud.
- Synchronises the asynchronous uart_rxd pin.
- Detects the start bit and validates it at mid-bit.
- Samples each data bit at its centre and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe.

Parameters:
- CLK_FREQ, 10_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate in bit/s.
- Derived localparam CNT_MAX = CLK_FREQ / BAUD_RATE: clocks per bit (86 at defaults).
- Derived localparam HALF = CNT_MAX / 2: clocks to mid-bit (43 at defaults).

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- uart_rxd, input, 1: serial line, asynchronous to clk, idles high.
- dout, output, 8: last correctly received byte.
- dat_valid, output, 1: one-cycle pulse when dout is updated.
- rx_busy, output, 1: high while a frame is being received.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset values:
  - dout = 8'h00; dat_valid = 0; rx_busy = 0; frame_err = 0; state = IDLE.
  - Synchroniser flops and rxd_prev reset to 1, so release from reset never produces a false edge.
- Input conditioning:
  - 2-flop synchroniser produces rxd_s.
  - rxd_prev is rxd_s delayed one cycle.
  - fall = rxd_prev & ~rxd_s.
- div_cnt: width $clog2(CNT_MAX). Cleared on every state transition and increments otherwise.
- bit_cnt: 3 bits, 0..7.
- State IDLE:
  - rx_busy = 0.
  - On fall: go to START, clear div_cnt.
  - A low level without a falling edge does not start a frame.
- State START:
  - rx_busy = 1.
  - When div_cnt == HALF-1, sample rxd_s:
    - rxd_s = 1 (glitch): return to IDLE; no pulse on any output.
    - rxd_s = 0: go to DATA, clear div_cnt and bit_cnt.
  - From this point all samples are aligned to bit centres.
- State DATA:
  - When div_cnt == CNT_MAX-1: shift rxd_s into shift_reg[7] (right shift, LSB first).
  - If bit_cnt == 7, go to STOP; otherwise increment bit_cnt.
- State STOP:
  - When div_cnt == CNT_MAX-1, sample rxd_s:
    - rxd_s = 1: dout <= shift_reg; dat_valid = 1 for exactly one cycle; go to IDLE.
    - rxd_s = 0: frame_err = 1 for one cycle; dout is unchanged; dat_valid stays 0; go to IDLE.
  - After a frame error, IDLE waits for the line to go high and then for a new falling edge, so a break condition yields one frame_err only.
- Latency:
  - dat_valid rises 9.5 bit periods + 3 clk (±1) after the start-bit falling edge at the pin.
  - The next frame can be detected from the cycle after dat_valid. This handles back-to-back frames whose start bit follows the stop bit immediately.
- Output timing:
  - rx_busy deasserts in the same cycle dat_valid or frame_err pulses.
  - dat_valid and frame_err are never high together.
- Reset mid-frame: asynchronous return to IDLE with all outputs at reset values; the partial byte is discarded.
- No overrun detection: dout is overwritten by each good frame, and the consumer must take it on dat_valid.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams (IDLE=0, START=1, DATA=2, STOP=3).
  - Function calc_cnt_max(CLK_FREQ, BAUD_RATE), also usable by uart_tx_core.
- Sub-module uart_rx_sync: 2-flop synchroniser plus edge detector. Outputs rxd_s and fall; reset value 1.
- FSM, counters and shift register live in uart_rx_core.

Test Plan:
All scenarios use the default parameters, so one bit = 86 clk.
1. Drive byte 8'hA5 as an 8N1 frame -> dat_valid pulses once; dout = 8'hA5; frame_err stays 0; rx_busy is high for about 9.5 bit periods.
2. Drive bytes 8'h00 and 8'hFF back-to-back with no idle gap -> two dat_valid pulses about 860 clk apart; dout = 8'h00, then 8'hFF.
3. Drive a 20-clk low glitch on an idle line -> no dat_valid, no frame_err; rx_busy returns to 0 by clk 43 after the glitch; next frame 8'h3C is received correctly.
4. Drive frame 8'h55 with the stop bit held low, then idle -> frame_err pulses once; dat_valid stays 0; dout keeps its previous value; next valid frame 8'h12 gives dout = 8'h12.
5. Assert rst during data bit 4 of a frame, release it, then send 8'hC3 -> outputs are 0 during reset; the partial frame produces no pulse; dout = 8'hC3 afterwards.
6. Drive 8'h81 at ±3% baud error -> dout = 8'h81 with no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit cores: state encoding and
// baud-divider helpers so both directions derive identical bit timing.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned calc_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        if (baud_rate == 0) begin
            return 1;
        end
        return clk_freq / baud_rate;
    endfunction

    // Counter width that can hold 0..cnt_max-1; never narrower than one bit.
    function automatic int unsigned calc_cnt_width(input int unsigned cnt_max);
        if (cnt_max <= 2) begin
            return 1;
        end
        return $clog2(cnt_max);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector; all flops reset high so reset release never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rxd_s = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first. Validates the start bit at mid-bit, then samples
// every data bit and the stop bit at its centre.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 10_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] dout,
    output logic       dat_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int unsigned CNT_MAX = calc_cnt_max(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF    = CNT_MAX / 2;
    localparam int unsigned CNT_W   = calc_cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic w_rxd_s;
    logic w_fall;

    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_div_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_dat_valid;
    logic                 r_rx_busy;
    logic                 r_frame_err;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_rxd   (uart_rxd),
        .o_rxd_s (w_rxd_s),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_dat_valid <= 1'b0;
            r_rx_busy   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dat_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_div_cnt   <= r_div_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    r_rx_busy <= 1'b0;
                    // Only an edge starts a frame: a held-low break stays here.
                    if (w_fall) begin
                        r_state   <= START;
                        r_div_cnt <= '0;
                        r_rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (r_div_cnt == HALF_LAST) begin
                        r_div_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state   <= IDLE;
                            r_rx_busy <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                end

                DATA: begin
                    if (r_div_cnt == CNT_LAST) begin
                        r_div_cnt <= '0;
                        r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (r_div_cnt == CNT_LAST) begin
                        r_div_cnt <= '0;
                        r_state   <= IDLE;
                        r_rx_busy <= 1'b0;
                        if (w_rxd_s) begin
                            r_dout      <= r_shift;
                            r_dat_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign dat_valid = r_dat_valid;
    assign rx_busy   = r_rx_busy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 10 MHz / 115200 baud (86 clk per bit).
module tb_uart_rx_core;

    localparam int BIT = 86;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] dout;
    logic       dat_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx_core #(
        .CLK_FREQ  (10_000_000),
        .BAUD_RATE (115200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .dout      (dout),
        .dat_valid (dat_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pulse counts, pulse widths, busy time, received bytes.
    int         n_valid = 0;
    int         n_err = 0;
    int         n_valid_hi = 0;
    int         n_err_hi = 0;
    int         n_busy = 0;
    int         n_overlap = 0;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] rx_bytes[$];

    always @(negedge clk) begin
        prev_valid <= dat_valid;
        prev_err   <= frame_err;
        if (dat_valid) n_valid_hi <= n_valid_hi + 1;
        if (frame_err) n_err_hi <= n_err_hi + 1;
        if (rx_busy) n_busy <= n_busy + 1;
        if (dat_valid && frame_err) n_overlap <= n_overlap + 1;
        if (frame_err && !prev_err) n_err <= n_err + 1;
        if (dat_valid && !prev_valid) begin
            n_valid        <= n_valid + 1;
            prev_valid_cyc <= last_valid_cyc;
            last_valid_cyc <= cyc;
            rx_bytes.push_back(dout);
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    int t_start = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got >= lo && got <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int bclk);
        t_start  = cyc;
        uart_rxd = 1'b0;
        wait_clks(bclk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = data[i];
            wait_clks(bclk);
        end
        uart_rxd = stop;
        wait_clks(bclk);
        uart_rxd = 1'b1;
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop;
        int         bclk;
        logic [7:0] exp_dout;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[7];

    // START 43 + DATA 8*86 + STOP 86 clk of busy per frame.
    localparam int BUSY_CLKS = 43 + 8 * BIT + BIT;

    initial begin
        int v0;
        int e0;
        int b0;
        int sz;
        int byte0;
        int byte1;

        vecs[0] = '{"a5",      8'hA5, 1'b1, BIT, 8'hA5, 1, 0};
        vecs[1] = '{"55 err",  8'h55, 1'b0, BIT, 8'hA5, 0, 1};
        vecs[2] = '{"12",      8'h12, 1'b1, BIT, 8'h12, 1, 0};
        vecs[3] = '{"3c",      8'h3C, 1'b1, BIT, 8'h3C, 1, 0};
        vecs[4] = '{"81 fast", 8'h81, 1'b1, 83,  8'h81, 1, 0};
        vecs[5] = '{"81 slow", 8'h81, 1'b1, 89,  8'h81, 1, 0};
        vecs[6] = '{"7e",      8'h7E, 1'b1, BIT, 8'h7E, 1, 0};

        wait_clks(5);
        check("rst dout", int'(dout), 0);
        check("rst dat_valid", int'(dat_valid), 0);
        check("rst rx_busy", int'(rx_busy), 0);
        check("rst frame_err", int'(frame_err), 0);
        rst = 1'b0;
        wait_clks(10);

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid;
            e0 = n_err;
            b0 = n_busy;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].bclk);
            wait_clks(2 * BIT);
            check({vecs[i].name, " valid pulses"}, n_valid - v0, vecs[i].exp_valid);
            check({vecs[i].name, " err pulses"}, n_err - e0, vecs[i].exp_err);
            check({vecs[i].name, " dout"}, int'(dout), int'(vecs[i].exp_dout));
            check_rng({vecs[i].name, " busy clks"}, n_busy - b0, BUSY_CLKS - 1, BUSY_CLKS + 1);
        end

        // Latency from pin falling edge to dat_valid: 9.5 bits + 3 clk.
        send_frame(8'h5A, 1'b1, BIT);
        wait_clks(2 * BIT);
        check("lat dout", int'(dout), 8'h5A);
        check_rng("lat clks", last_valid_cyc - t_start, 819, 821);

        // Back-to-back frames, start bit directly after stop bit.
        v0 = n_valid;
        sz = rx_bytes.size();
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        wait_clks(2 * BIT);
        check("b2b pulses", n_valid - v0, 2);
        byte0 = (rx_bytes.size() > sz) ? int'(rx_bytes[sz]) : -1;
        byte1 = (rx_bytes.size() > sz + 1) ? int'(rx_bytes[sz + 1]) : -1;
        check("b2b byte0", byte0, 8'h00);
        check("b2b byte1", byte1, 8'hFF);
        check_rng("b2b spacing", last_valid_cyc - prev_valid_cyc, 10 * BIT - 1, 10 * BIT + 1);

        // 20-clk glitch: start detected, rejected at mid-bit.
        v0 = n_valid;
        e0 = n_err;
        uart_rxd = 1'b0;
        wait_clks(20);
        uart_rxd = 1'b1;
        check("glitch busy seen", int'(rx_busy), 1);
        wait_clks(40);
        check("glitch busy clear", int'(rx_busy), 0);
        wait_clks(2 * BIT);
        check("glitch valid", n_valid - v0, 0);
        check("glitch err", n_err - e0, 0);
        send_frame(8'h3C, 1'b1, BIT);
        wait_clks(2 * BIT);
        check("post glitch dout", int'(dout), 8'h3C);
        check("post glitch valid", n_valid - v0, 1);

        // Reset in the middle of data bit 4; remaining bits and stop are high.
        v0 = n_valid;
        e0 = n_err;
        fork
            send_frame(8'hF0, 1'b1, BIT);
            begin
                wait_clks(5 * BIT + 43);
                check("pre rst busy", int'(rx_busy), 1);
                rst = 1'b1;
                wait_clks(2);
                check("mid rst dout", int'(dout), 0);
                check("mid rst dat_valid", int'(dat_valid), 0);
                check("mid rst rx_busy", int'(rx_busy), 0);
                check("mid rst frame_err", int'(frame_err), 0);
                wait_clks(3);
                rst = 1'b0;
            end
        join
        wait_clks(2 * BIT);
        check("rst frame valid", n_valid - v0, 0);
        check("rst frame err", n_err - e0, 0);
        check("rst frame busy", int'(rx_busy), 0);
        send_frame(8'hC3, 1'b1, BIT);
        wait_clks(2 * BIT);
        check("post rst dout", int'(dout), 8'hC3);
        check("post rst valid", n_valid - v0, 1);

        check("valid width", n_valid_hi, n_valid);
        check("err width", n_err_hi, n_err);
        check("valid err overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
